shift_right_iterative: RTL and testbench

Multi-cycle right shifter for the CPU datapath. It executes SRL/SRA/SRLV/SRAV-class operations on a 32-bit operand, shifting up to STEP bit positions per clock under a start/done handshake. It is the right-shift counterpart of the combinational left-shift helpers. It sits beside the ALU and is used when a shift instruction is issued to the multi-cycle unit; the controller stalls on busy_o.

---
 rtl/shift_right_iterative_pkg.sv | 20 ++
 rtl/shift_right_step.sv | 31 +++
 rtl/shift_right_iterative.sv | 112 +++++++++++
 tb/tb_shift_right_iterative.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_right_iterative_pkg.sv
// Shared definitions for the iterative right shifter: FSM encodings, shift-type opcodes
// and the width helper for the per-cycle shift amount.
package shift_right_iterative_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Shift-type opcodes, also used by the ALU control decoder.
  localparam logic ShiftOpSrl = 1'b0;
  localparam logic ShiftOpSra = 1'b1;

  // Bits needed to encode a per-cycle shift amount of 0..step.
  function automatic int unsigned amt_width(int unsigned step);
    return $clog2(step) + 1;
  endfunction

endpackage

// File: rtl/shift_right_step.sv
// Combinational single-step right shifter: shifts by amt_i (0..STEP) and fills vacated
// MSBs with fill_i.
module shift_right_step
  import shift_right_iterative_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1,
  localparam int unsigned AmtW = amt_width(STEP)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [AmtW-1:0]  amt_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] cand [STEP+1];

  assign cand[0] = data_i;

  for (genvar s = 1; s <= STEP; s++) begin : g_cand
    assign cand[s] = {{s{fill_i}}, data_i[WIDTH-1:s]};
  end

  always_comb begin
    data_o = cand[0];
    for (int unsigned s = 1; s <= STEP; s++) begin
      if (amt_i == AmtW'(s)) data_o = cand[s];
    end
  end

endmodule

// File: rtl/shift_right_iterative.sv
// Multi-cycle SRL/SRA unit: shifts a latched operand right by up to STEP bits per clock
// under a start/done handshake.
module shift_right_iterative
  import shift_right_iterative_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [4:0]       shamt_i,
  input  logic             arith_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int unsigned AmtW    = amt_width(STEP);
  localparam logic [4:0]  StepCnt = 5'(STEP);

  state_e           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             mode_q, mode_d;
  logic             sign_q, sign_d;

  logic             accept;
  logic [4:0]       k;
  logic [AmtW-1:0]  k_amt;
  logic [4:0]       cnt_rem;
  logic             fill;
  logic [WIDTH-1:0] shifted;

  assign accept  = (state_q == StIdle) && start_i;
  assign k       = (cnt_q < StepCnt) ? cnt_q : StepCnt;
  assign k_amt   = AmtW'(k);
  assign cnt_rem = cnt_q - k;
  // Sign is captured at accept so the fill stays fixed while the register drains.
  assign fill    = (mode_q == ShiftOpSra) && sign_q;

  shift_right_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data_i (work_q),
    .amt_i  (k_amt),
    .fill_i (fill),
    .data_o (shifted)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = (shamt_i != 5'd0) ? StShift : StDone;
      end
      StShift: begin
        if (cnt_rem == 5'd0) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o = (state_q != StIdle);
    done_o = (state_q == StDone);
  end

  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    sign_d = sign_q;
    if (accept) begin
      work_d = data_i;
      cnt_d  = shamt_i;
      mode_d = arith_i;
      sign_d = data_i[WIDTH-1];
    end else if (state_q == StShift) begin
      work_d = shifted;
      cnt_d  = cnt_rem;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      work_q <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      sign_q <= 1'b0;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      sign_q <= sign_d;
    end
  end

  assign result_o = work_q;

endmodule

// File: tb/tb_shift_right_iterative.sv
// Directed bench for shift_right_iterative: one STEP=1 and one STEP=4 instance share
// clock, reset and operand inputs; each has its own start.
module tb_shift_right_iterative;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0;
  logic        start4 = 1'b0;
  logic [31:0] data = '0;
  logic [4:0]  shamt = '0;
  logic        arith = 1'b0;
  logic        busy1, done1, busy4, done4;
  logic [31:0] res1, res4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_right_iterative #(.WIDTH(32), .STEP(1)) u_dut1 (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .start_i  (start1),
    .data_i   (data),
    .shamt_i  (shamt),
    .arith_i  (arith),
    .busy_o   (busy1),
    .done_o   (done1),
    .result_o (res1)
  );

  shift_right_iterative #(.WIDTH(32), .STEP(4)) u_dut4 (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .start_i  (start4),
    .data_i   (data),
    .shamt_i  (shamt),
    .arith_i  (arith),
    .busy_o   (busy4),
    .done_o   (done4),
    .result_o (res4)
  );

  // Issue one request at a negedge; return cycle index of done (accept edge + lat), busy
  // cycles seen, and the result in DONE. lat = -1 if done never arrives.
  task automatic run_op(input bit use4, input logic [31:0] d, input logic [4:0] sh,
                        input logic ar, output int lat, output int busy_cnt,
                        output logic [31:0] res);
    data = d;
    shamt = sh;
    arith = ar;
    if (use4) start4 = 1'b1;
    else start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    start4 = 1'b0;
    lat = -1;
    busy_cnt = 0;
    res = '0;
    for (int c = 1; c <= 64; c++) begin
      if (c > 1) @(negedge clk);
      if (use4 ? busy4 : busy1) busy_cnt++;
      if (use4 ? done4 : done1) begin
        lat = c;
        res = use4 ? res4 : res1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1 got %b want 0", busy1); end
    checks++;
    if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done1 got %b want 0", done1); end
    checks++;
    if (res1 !== 32'h0) begin errors++; $display("FAIL reset_res1 got %h want 0", res1); end
    checks++;
    if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy4 got %b want 0", busy4); end
    checks++;
    if (done4 !== 1'b0) begin errors++; $display("FAIL reset_done4 got %b want 0", done4); end
    checks++;
    if (res4 !== 32'h0) begin errors++; $display("FAIL reset_res4 got %h want 0", res4); end
  endtask

  task automatic test_sra_step1();
    int lat, bc;
    logic [31:0] r;
    run_op(1'b0, 32'h8000_0000, 5'd4, 1'b1, lat, bc, r);
    checks++;
    if (r !== 32'hF800_0000) begin errors++; $display("FAIL sra4_result got %h want f8000000", r); end
    checks++;
    if (lat != 5) begin errors++; $display("FAIL sra4_latency got %0d want 5", lat); end
    checks++;
    if (bc != 5) begin errors++; $display("FAIL sra4_busy_cycles got %0d want 5", bc); end
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL sra4_after_done got busy=%b done=%b want 0 0", busy1, done1);
    end
  endtask

  task automatic test_shift31();
    int lat, bc;
    logic [31:0] r;
    run_op(1'b0, 32'h8000_0000, 5'd31, 1'b0, lat, bc, r);
    checks++;
    if (r !== 32'h0000_0001) begin errors++; $display("FAIL srl31_result got %h want 1", r); end
    checks++;
    if (lat != 32) begin errors++; $display("FAIL srl31_latency got %0d want 32", lat); end
    @(negedge clk);
    run_op(1'b0, 32'h8000_0000, 5'd31, 1'b1, lat, bc, r);
    checks++;
    if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sra31_result got %h want ffffffff", r); end
    checks++;
    if (lat != 32) begin errors++; $display("FAIL sra31_latency got %0d want 32", lat); end
    @(negedge clk);
  endtask

  task automatic test_zero_shamt();
    int lat, bc;
    logic [31:0] r;
    for (int m = 0; m < 2; m++) begin
      run_op(1'b0, 32'h1234_5678, 5'd0, m[0], lat, bc, r);
      checks++;
      if (r !== 32'h1234_5678) begin
        errors++;
        $display("FAIL zero_result mode=%0d got %h want 12345678", m, r);
      end
      checks++;
      if (lat != 1) begin errors++; $display("FAIL zero_latency mode=%0d got %0d want 1", m, lat); end
      @(negedge clk);
    end
  endtask

  task automatic test_step4();
    int lat, bc;
    logic [31:0] r;
    run_op(1'b1, 32'hF000_000F, 5'd7, 1'b0, lat, bc, r);
    checks++;
    if (r !== 32'h01E0_0000) begin errors++; $display("FAIL step4_srl7 got %h want 01e00000", r); end
    checks++;
    if (lat != 3) begin errors++; $display("FAIL step4_srl7_latency got %0d want 3", lat); end
    @(negedge clk);
    run_op(1'b1, 32'h8000_0000, 5'd31, 1'b1, lat, bc, r);
    checks++;
    if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL step4_sra31 got %h want ffffffff", r); end
    checks++;
    if (lat != 9) begin errors++; $display("FAIL step4_sra31_latency got %0d want 9", lat); end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int lat = -1;
    logic [31:0] r = '0;
    data = 32'h0000_FF00;
    shamt = 5'd4;
    arith = 1'b0;
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    data = 32'hFFFF_FFFF;
    shamt = 5'd1;
    arith = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 2) start1 = 1'b1;
      if (c == 3) start1 = 1'b0;
      if (done1) begin
        lat = c;
        r = res1;
        break;
      end
    end
    checks++;
    if (r !== 32'h0000_0FF0) begin errors++; $display("FAIL ignore_result got %h want 00000ff0", r); end
    checks++;
    if (lat != 5) begin errors++; $display("FAIL ignore_latency got %0d want 5", lat); end
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL ignore_idle_busy got %b want 0", busy1); end
  endtask

  task automatic test_back_to_back();
    int d1 = -1, d2 = -1;
    logic [31:0] r1 = '0, r2 = '0;
    logic idle_busy = 1'bx;
    data = 32'h0000_FF00;
    shamt = 5'd2;
    arith = 1'b0;
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data = 32'h8000_0010;
    shamt = 5'd3;
    arith = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 4) idle_busy = busy1;
      if (c == 5) start1 = 1'b0;
      if (done1 && c <= 4) begin d1 = c; r1 = res1; end
      if (done1 && c > 4) begin d2 = c; r2 = res1; break; end
    end
    start1 = 1'b0;
    checks++;
    if (r1 !== 32'h0000_3FC0) begin errors++; $display("FAIL b2b_first_result got %h want 00003fc0", r1); end
    checks++;
    if (d1 != 3) begin errors++; $display("FAIL b2b_first_latency got %0d want 3", d1); end
    checks++;
    if (idle_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap got busy=%b want 0", idle_busy); end
    checks++;
    if (r2 !== 32'hF000_0002) begin errors++; $display("FAIL b2b_second_result got %h want f0000002", r2); end
    checks++;
    if (d2 != 8) begin errors++; $display("FAIL b2b_second_latency got %0d want 8", d2); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int lat, bc;
    logic [31:0] r;
    logic saw_done = 1'b0;
    data = 32'h1234_5678;
    shamt = 5'd10;
    arith = 1'b0;
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b want 1", busy1); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy1 !== 1'b0 || res1 !== 32'h0) begin
      errors++;
      $display("FAIL abort_async_clear got busy=%b res=%h want 0 0", busy1, res1);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done1 !== 1'b0) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done1 !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b want 0", saw_done); end
    run_op(1'b0, 32'h0000_0100, 5'd8, 1'b0, lat, bc, r);
    checks++;
    if (r !== 32'h0000_0001) begin errors++; $display("FAIL abort_next_result got %h want 1", r); end
    checks++;
    if (lat != 9) begin errors++; $display("FAIL abort_next_latency got %0d want 9", lat); end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_sra_step1();
    test_shift31();
    test_zero_shamt();
    test_step4();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
